image_storer: RTL and testbench
===============================

IMAGE_STORER -- requirements
Module: image_storer

Interface
REQ-001 Parameter IMG_W, default 200: pixels per line.
REQ-002 Parameter IMG_H, default 200: lines per frame.
REQ-003 Parameter ADDR_W, default 16: memory address width, SHALL satisfy 2^ADDR_W >= IMG_W*IMG_H.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin storing a frame.
REQ-007 abort  input  1  cancels the frame in progress.
REQ-008 pix_valid  input  1  pixel on pix_data is valid.
REQ-009 pix_data  input  8  grayscale pixel value.
REQ-010 pix_ready  output  1  block accepts a pixel this cycle.
REQ-011 mem_we  output  1  write strobe to frame RAM.
REQ-012 mem_addr  output  ADDR_W  frame RAM write address.
REQ-013 mem_wdata  output  8  frame RAM write data.
REQ-014 x  output  8  column of the next pixel to accept.
REQ-015 y  output  8  line of the next pixel to accept.
REQ-016 busy  output  1  frame store in progress.
REQ-017 done  output  1  one-cycle pulse after the last pixel is written.

Function
REQ-018 FSM states SHALL be IDLE, STORE, FLUSH and DONE.
REQ-019 In IDLE, pix_ready=0 and busy=0; start=1 moves to STORE, clears x, y and the address counter to 0.
REQ-020 In STORE, pix_ready=1 and busy=1; a pixel is accepted only on a cycle with pix_valid=1 and pix_ready=1.
REQ-021 Accepted pixel SHALL appear on the following cycle as mem_we=1, mem_wdata=pix_data, mem_addr=y*IMG_W+x of that pixel (1-cycle registered latency).
REQ-022 mem_addr SHALL be produced by an incrementing counter, not a multiplier; it increments by 1 per accepted pixel.
REQ-023 x increments per accepted pixel; at x=IMG_W-1 it wraps to 0 and y increments.
REQ-024 Acceptance of pixel (IMG_W-1, IMG_H-1) moves STORE to FLUSH, and pix_ready drops to 0 in the same cycle as the FSM leaves STORE.
REQ-025 FLUSH lasts exactly one cycle, during which the final mem_we is issued, then goes to DONE.
REQ-026 DONE asserts done=1 for exactly one cycle, busy=1, then goes to IDLE.
REQ-027 pix_valid=0 in STORE stalls: no write, counters held, mem_we=0 next cycle.
REQ-028 start while not in IDLE SHALL be ignored.
REQ-029 abort=1 in STORE or FLUSH returns to IDLE next cycle, sets mem_we=0 from that cycle on, and never pulses done; a pixel presented together with abort is not accepted.
REQ-030 If abort and start are both 1 in IDLE, abort wins and the FSM stays in IDLE.
REQ-031 When mem_we=0, mem_addr and mem_wdata hold their last values.
REQ-032 Frame total is exactly IMG_W*IMG_H writes with addresses 0..IMG_W*IMG_H-1; no address is written twice and none is skipped.

Reset
REQ-033 rst=1 SHALL immediately force the FSM to IDLE and set pix_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, x=0, y=0, busy=0, done=0, independent of clk.
REQ-034 Reset asserted mid-frame discards the frame; no write or done pulse follows reset release until a new start.

Verification
REQ-035 Full frame, pix_valid held 1, start at cycle 0: exactly 40000 mem_we pulses, addresses 0..39999 in order, done high once, at cycle 40002 after start.
REQ-036 Line wrap: after 200 accepted pixels -> x=0, y=1, next write mem_addr=200.
REQ-037 Stalls: pix_valid toggled 1/0 each cycle -> writes only follow valid cycles; data matches the sequence sent; addresses contiguous.
REQ-038 Abort at pixel 500 -> returns to IDLE, no further mem_we, done never asserts; a new start restarts at address 0.
REQ-039 Async reset asserted between clock edges at pixel 1000 -> all outputs are at reset values before the next edge; start afterwards begins at x=0, y=0.
REQ-040 start pulsed during STORE, and start+abort together in IDLE -> no effect on counters or state.

Source files
------------

// File: rtl/image_storer.sv
`default_nettype none
// ============================================================================
// Module   : image_storer
// Purpose  : Accepts a raster-ordered grayscale pixel stream and writes one
//            frame into a linear frame RAM with a 1-cycle registered write port.
// Revision : 1.0  initial release
// ============================================================================
module image_storer #(
    parameter int IMG_W  = 200,
    parameter int IMG_H  = 200,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic              pix_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [7:0]        x,
    output logic [7:0]        y,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] c_X_LAST = 8'(IMG_W - 1);
    localparam logic [7:0] c_Y_LAST = 8'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STORE = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          x_q, x_d;
    logic [7:0]          y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [7:0]          wdata_q, wdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        pix_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_STORE;
                    x_d     = 8'd0;
                    y_d     = 8'd0;
                    addr_d  = '0;
                end
            end

            S_STORE: begin
                pix_ready = 1'b1;
                busy      = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (pix_valid) begin
                    // Address is the running pixel count, so it equals y*IMG_W+x.
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = pix_data;
                    addr_d  = addr_q + 1'b1;
                    if (x_q == c_X_LAST) begin
                        x_d = 8'd0;
                        if (y_q == c_Y_LAST) begin
                            y_d     = 8'd0;
                            state_d = S_FLUSH;
                        end else begin
                            y_d = y_q + 8'd1;
                        end
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end
            end

            S_FLUSH: begin
                busy    = 1'b1;
                state_d = abort ? S_IDLE : S_DONE;
            end

            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_we    = we_q;
    assign mem_addr  = waddr_q;
    assign mem_wdata = wdata_q;
    assign x         = x_q;
    assign y         = y_q;

endmodule
`default_nettype wire

// File: tb/tb_image_storer.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_storer
// Purpose  : Randomized self-checking bench for image_storer against a
//            pixel-count reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_image_storer;

    localparam int W     = 200;
    localparam int H     = 200;
    localparam int AW    = 16;
    localparam int TOTAL = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          pix_valid;
    logic [7:0]    pix_data;
    logic          pix_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    x;
    logic [7:0]    y;
    logic          busy;
    logic          done;

    image_storer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .x         (x),
        .y         (y),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 idle, 1 storing, 2 flush, 3 done; n = pixels accepted.
    int            m_phase   = 0;
    int            n         = 0;
    logic          exp_we    = 1'b0;
    logic [AW-1:0] exp_addr  = '0;
    logic [7:0]    exp_data  = 8'd0;
    int            call_idx  = 0;
    int            start_idx = 0;
    int            we_cnt    = 0;
    int            done_cnt  = 0;
    int            done_cyc  = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(pix_ready), 32'd0);
        check({tag, "_we"},    32'(mem_we),    32'd0);
        check({tag, "_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_x"},     32'(x),         32'd0);
        check({tag, "_y"},     32'(y),         32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
    endtask

    task automatic model_reset();
        m_phase  = 0;
        n        = 0;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = 8'd0;
    endtask

    // One clock: drive at the falling edge, advance the model, compare after the rising edge.
    task automatic cycle(input logic s, input logic a, input logic v, input logic [7:0] d);
        @(negedge clk);
        start     = s;
        abort     = a;
        pix_valid = v;
        pix_data  = d;
        exp_we    = 1'b0;
        case (m_phase)
            0: if (s && !a) begin
                   m_phase   = 1;
                   n         = 0;
                   start_idx = call_idx;
               end
            1: if (a) begin
                   m_phase = 0;
               end else if (v) begin
                   exp_we   = 1'b1;
                   exp_addr = AW'(n);
                   exp_data = d;
                   n++;
                   if (n == TOTAL) m_phase = 2;
               end
            2: m_phase = a ? 0 : 3;
            default: m_phase = 0;
        endcase
        @(posedge clk);
        #1;
        check("we",    32'(mem_we),    32'(exp_we));
        check("addr",  32'(mem_addr),  32'(exp_addr));
        check("wdata", 32'(mem_wdata), 32'(exp_data));
        check("ready", 32'(pix_ready), 32'(m_phase == 1));
        check("busy",  32'(busy),      32'(m_phase != 0));
        check("done",  32'(done),      32'(m_phase == 3));
        check("x",     32'(x),         32'((n % TOTAL) % W));
        check("y",     32'(y),         32'((n % TOTAL) / W));
        if (mem_we) we_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = call_idx - start_idx + 1;
        end
        call_idx++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'd0;
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        // Idle traffic must not write.
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));

        // start together with abort in IDLE has no effect.
        cycle(1'b1, 1'b1, 1'b1, 8'($urandom));
        check("sa_busy", 32'(busy), 32'd0);
        check("sa_ready", 32'(pix_ready), 32'd0);

        // Full frame, pix_valid held high, stray start pulses during the frame.
        we_cnt = 0; done_cnt = 0; done_cyc = -1;
        cycle(1'b1, 1'b0, 1'b1, 8'($urandom));
        guard = 0;
        while (m_phase != 0 && guard < TOTAL + 100) begin
            cycle(1'($urandom_range(0, 49) == 0), 1'b0, 1'b1, 8'($urandom));
            if (exp_we && n == W) begin
                check("wrap_x", 32'(x), 32'd0);
                check("wrap_y", 32'(y), 32'd1);
            end
            guard++;
        end
        check("frame_end", 32'(m_phase), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
        check("frame_writes", 32'(we_cnt), 32'(TOTAL));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("done_cycle", 32'(done_cyc), 32'(TOTAL + 2));

        // Alternating pix_valid stalls, then abort.
        cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        for (int i = 0; i < 600; i++) cycle(1'b0, 1'b0, 1'(i % 2 == 0), 8'($urandom));
        check("stall_count", 32'(n), 32'd300);
        cycle(1'b0, 1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom));

        // Random valid until 500 pixels, abort with a pixel presented.
        cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        guard = 0;
        while (n < 500 && guard < 5000) begin
            cycle(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom));
            guard++;
        end
        check("abort_reach500", 32'(n), 32'd500);
        cycle(1'b0, 1'b1, 1'b1, 8'($urandom));
        we_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
        check("abort_no_we", 32'(we_cnt), 32'd0);
        check("abort_no_done", 32'(done_cnt), 32'd0);

        // Restart begins at address 0.
        cycle(1'b1, 1'b0, 1'b1, 8'($urandom));
        cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
        check("restart_we", 32'(mem_we), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'd0);
        guard = 0;
        while (n < 1000 && guard < 5000) begin
            cycle(1'b0, 1'b0, 1'($urandom_range(0, 4) != 0), 8'($urandom));
            guard++;
        end
        check("rst_reach1000", 32'(n), 32'd1000);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        start = 1'b0; abort = 1'b0; pix_valid = 1'b1;
        #1 rst = 1'b1;
        #1 check_reset_outputs("arst");
        model_reset();
        #1 rst = 1'b0;
        we_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
        check("post_rst_no_we", 32'(we_cnt), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        check("post_rst_x", 32'(x), 32'd0);
        check("post_rst_y", 32'(y), 32'd0);
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
